// File: rtl/am_pkg.sv
// Shared types and constants for the approximate-multiplier dot-product accumulator.
package am_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } am_acc_state_t;

    localparam int AM_PROD_W = 16;

    // All-ones value of a w-bit accumulator, used as the saturation ceiling.
    function automatic logic [63:0] am_sat_ones(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/am_sat_add.sv
// Combinational saturating adder: accumulator plus zero-extended product,
// clamped to all-ones on carry-out with an overflow indication.
module am_sat_add
    import am_pkg::*;
#(
    parameter int PROD_W = AM_PROD_W,
    parameter int ACC_W  = 24
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);

    localparam logic [ACC_W-1:0] L_SAT = ACC_W'(am_sat_ones(ACC_W));

    logic [ACC_W:0] w_sum;

    assign w_sum = {1'b0, i_acc} + (ACC_W+1)'(i_prod);
    assign o_ovf = w_sum[ACC_W];
    assign o_sum = w_sum[ACC_W] ? L_SAT : w_sum[ACC_W-1:0];

endmodule

// File: rtl/am_dot_accum.sv
// Dot-product accumulator: sums a programmed number of products with
// saturation, then holds the result behind a valid/ready output handshake.
module am_dot_accum
    import am_pkg::*;
#(
    parameter int PROD_W = AM_PROD_W,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              busy
);

    am_acc_state_t r_state;
    am_acc_state_t w_next;

    logic [LEN_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             w_beat;
    logic [ACC_W-1:0] w_sum;
    logic             w_sum_ovf;

    am_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .i_acc  (r_acc),
        .i_prod (prod_in),
        .o_sum  (w_sum),
        .o_ovf  (w_sum_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort outranks every transition and suppresses a same-cycle beat.
    always_comb begin
        w_next = r_state;
        w_beat = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                w_beat = prod_valid;
                if (prod_valid && r_cnt == LEN_W'(1)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (abort) begin
            w_next = IDLE;
            w_beat = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (!abort) begin
            if (r_state == IDLE && start) begin
                r_cnt <= len;
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (w_beat) begin
                r_cnt <= r_cnt - LEN_W'(1);
                r_acc <= w_sum;
                r_ovf <= r_ovf | w_sum_ovf;
            end
        end
    end

    assign prod_ready = (r_state == ACCUM);
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign acc_out    = r_acc;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_am_dot_accum.sv
// Scoreboard bench for am_dot_accum: directed sequences push expected
// results; a negedge monitor pops and compares on each output handshake.
module tb_am_dot_accum;

    localparam int PW = 16;
    localparam int AW = 18;
    localparam int LW = 8;

    typedef struct {
        logic [AW-1:0] acc;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          abort = 1'b0;
    logic [PW-1:0] prod_in = '0;
    logic          prod_valid = 1'b0;
    logic          prod_ready;
    logic [AW-1:0] acc_out;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          overflow;
    logic          busy;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    logic [PW-1:0] vec[8];

    am_dot_accum #(
        .PROD_W (PW),
        .ACC_W  (AW),
        .LEN_W  (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_acc", 32'(acc_out), 32'(e.acc));
                chk("sb_ovf", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one sequence of n products from vec[], with gap idle cycles
    // between beats and hold cycles of output backpressure in DONE.
    task automatic run_seq(input int n, input int gap, input int hold,
                           input logic [AW-1:0] e_acc, input logic e_ovf);
        exp_t e;
        e.acc = e_acc;
        e.ovf = e_ovf;
        sb_q.push_back(e);
        out_ready = (hold == 0);
        start = 1'b1;
        len = LW'(n);
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            prod_valid = 1'b1;
            prod_in = vec[i];
            chk("prod_ready_accum", 32'(prod_ready), 32'd1);
            step();
            prod_valid = 1'b0;
            prod_in = 16'hdead;
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    chk("no_valid_in_gap", 32'(out_valid), 32'd0);
                    step();
                end
            end
        end
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("done_prod_ready", 32'(prod_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            len = 8'd3;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_acc", 32'(acc_out), 32'(e_acc));
            chk("hold_ovf", 32'(overflow), 32'(e_ovf));
            step();
        end
        start = 1'b0;
        out_ready = 1'b1;
        step();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_acc", 32'(acc_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(prod_ready), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #10;
        rst_n = 1'b1;
        step();

        vec[0] = 16'd100; vec[1] = 16'd200; vec[2] = 16'd300;
        run_seq(3, 0, 0, 18'd600, 1'b0);

        for (int i = 0; i < 4; i++) vec[i] = 16'd1000;
        run_seq(4, 2, 0, 18'd4000, 1'b0);

        for (int i = 0; i < 5; i++) vec[i] = 16'd65535;
        run_seq(5, 0, 10, 18'd262143, 1'b1);

        run_seq(0, 0, 0, 18'd0, 1'b0);

        // Abort after two of five beats, asserted alongside a third beat.
        start = 1'b1;
        len = 8'd5;
        step();
        start = 1'b0;
        vec[0] = 16'd10; vec[1] = 16'd20;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1;
            prod_in = vec[i];
            step();
        end
        prod_in = 16'd40;
        abort = 1'b1;
        step();
        abort = 1'b0;
        prod_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(prod_ready), 32'd0);
        chk("abort_acc_kept", 32'(acc_out), 32'd30);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_valid", 32'(out_valid), 32'd0);
            step();
        end
        vec[0] = 16'd7;
        run_seq(1, 0, 0, 18'd7, 1'b0);

        // Asynchronous reset while holding a result in DONE.
        out_ready = 1'b0;
        start = 1'b1;
        len = 8'd1;
        step();
        start = 1'b0;
        prod_valid = 1'b1;
        prod_in = 16'd5;
        step();
        prod_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_acc", 32'(acc_out), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_acc", 32'(acc_out), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ready", 32'(prod_ready), 32'd0);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
